// File: rtl/sp_ram_banked_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_banked_pkg
// Shared types and helpers for the banked single-port RAM wrapper.
//   ram_state_e     : wrapper state (INIT zeroing sequence, IDLE serving).
//   idx_width()     : index width for an n-entry select, never below 1 bit.
//   bank_sel_width(): width of the bank select field.
//   row_sel_width() : width of the row (word-in-bank) field.
// -----------------------------------------------------------------------------
package sp_ram_banked_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } ram_state_e;

  // A single-entry select still needs a 1-bit signal to be legal SV; the
  // users mask that bit to zero so it never addresses anything.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bank_sel_width(input int num_banks);
    return idx_width(num_banks);
  endfunction

  function automatic int row_sel_width(input int bank_words);
    return idx_width(bank_words);
  endfunction

endpackage

// File: rtl/sp_ram_bank_cell.sv
// -----------------------------------------------------------------------------
// sp_ram_bank_cell
// Behavioural single-port bank; written to map onto a technology RAM macro.
// Synchronous read (data valid after the edge that captured the read),
// byte-enable write. The read register only updates on reads, so o_rdata
// holds its value across writes and idle cycles.
// Ports:
//   clk      : clock
//   i_en     : bank enable (access this cycle)
//   i_we     : 1 = write, 0 = read
//   i_be     : byte enables for writes
//   i_addr   : row address
//   i_wdata  : write data
//   o_rdata  : registered read data
// -----------------------------------------------------------------------------
module sp_ram_bank_cell
  import sp_ram_banked_pkg::*;
#(
  parameter int WORDS      = 2048,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          i_en,
  input  logic                          i_we,
  input  logic [DATA_WIDTH/8-1:0]       i_be,
  input  logic [row_sel_width(WORDS)-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  output logic [DATA_WIDTH-1:0]         o_rdata
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // NOTE: the array and its read register carry no reset: RAM macros have
  // none, and a reset term would stop the array mapping onto one. The
  // wrapper's INIT sequence and output muxing provide the defined values.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sp_ram_banked_wrap.sv
// -----------------------------------------------------------------------------
// sp_ram_banked_wrap
// Byte-addressed single-port RAM split into NUM_BANKS contiguous word banks.
// Only the addressed bank is enabled per access. Optional output register
// (RDATA_REG), optional post-reset zeroing of the whole array (INIT_ON_RESET)
// with ready_o held low meanwhile, and a bypass mode that echoes write data
// back as a read response without touching the array.
// Ports:
//   clk          : clock
//   rstn_i       : asynchronous active-low reset
//   en_i         : access request (accepted when ready_o = 1)
//   addr_i       : byte address (low log2(DATA_WIDTH/8) bits ignored)
//   wdata_i      : write data / bypass data
//   we_i         : 1 = write, 0 = read
//   be_i         : byte enables for writes
//   bypass_en_i  : echo wdata_i instead of accessing the array
//   ready_o      : wrapper accepts requests
//   rvalid_o     : single-cycle pulse, rdata_o holds a new response
//   rdata_o      : read / bypass data, held until the next response
// -----------------------------------------------------------------------------
module sp_ram_banked_wrap
  import sp_ram_banked_pkg::*;
#(
  parameter int NUM_BANKS     = 4,
  parameter int BANK_WORDS    = 2048,
  parameter int DATA_WIDTH    = 32,
  parameter int RDATA_REG     = 0,
  parameter int INIT_ON_RESET = 1,
  parameter int ADDR_WIDTH    = $clog2(NUM_BANKS * BANK_WORDS * DATA_WIDTH / 8)
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic                    bypass_en_i,
  output logic                    ready_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(BE_W);
  localparam int ROW_RAW  = $clog2(BANK_WORDS);
  localparam int ROW_W    = row_sel_width(BANK_WORDS);
  localparam int BANK_W   = bank_sel_width(NUM_BANKS);
  localparam logic [ROW_W-1:0]  ROW_MASK  = ROW_W'(BANK_WORDS - 1);
  localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BANKS - 1);
  localparam ram_state_e RESET_STATE = (INIT_ON_RESET != 0) ? INIT : IDLE;

  // ---------------------------------------------------------------------------
  // Address split: word index, then row in the low bits and bank above it.
  // Masks force single-bank / single-row configurations to index 0.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_word_hi;
  logic [ROW_W-1:0]      w_row;
  logic [BANK_W-1:0]     w_bank;
  logic                  w_unused_addr_bits;

  assign w_word    = addr_i >> OFF_W;
  assign w_word_hi = w_word >> ROW_RAW;
  assign w_row     = w_word[ROW_W-1:0] & ROW_MASK;
  assign w_bank    = w_word_hi[BANK_W-1:0] & BANK_MASK;
  // Address bits above the decoded range alias onto the array.
  assign w_unused_addr_bits = ^{w_word, w_word_hi};

  // ---------------------------------------------------------------------------
  // State machine: INIT sweeps every row once, then IDLE forever.
  // ---------------------------------------------------------------------------
  ram_state_e       r_state;
  ram_state_e       w_state_nxt;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row_nxt;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= RESET_STATE;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    ready_o     = 1'b0;
    case (r_state)
      INIT: begin
        w_row_nxt = r_row + ROW_W'(1);
        if (r_row == ROW_MASK) begin
          w_state_nxt = IDLE;
          w_row_nxt   = '0;
        end
      end
      IDLE: begin
        ready_o = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  logic w_accept;
  logic w_array_acc;

  assign w_accept    = en_i & ready_o;
  assign w_array_acc = w_accept & ~bypass_en_i;

  // ---------------------------------------------------------------------------
  // Bank drive: INIT writes zero to the current row of every bank at once;
  // otherwise only the addressed bank is enabled.
  // ---------------------------------------------------------------------------
  logic [NUM_BANKS-1:0]  w_bank_en;
  logic                  w_bank_we;
  logic [BE_W-1:0]       w_bank_be;
  logic [ROW_W-1:0]      w_bank_addr;
  logic [DATA_WIDTH-1:0] w_bank_wdata;
  logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

  always_comb begin
    w_bank_en    = '0;
    w_bank_we    = 1'b0;
    w_bank_be    = '0;
    w_bank_addr  = '0;
    w_bank_wdata = '0;
    if (r_state == INIT) begin
      w_bank_en    = '1;
      w_bank_we    = 1'b1;
      w_bank_be    = '1;
      w_bank_addr  = r_row;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        w_bank_en[b] = w_array_acc && (w_bank == BANK_W'(b));
      end
      w_bank_we    = we_i;
      w_bank_be    = be_i;
      w_bank_addr  = w_row;
      w_bank_wdata = wdata_i;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sp_ram_bank_cell #(
      .WORDS      (BANK_WORDS),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .clk     (clk),
      .i_en    (w_bank_en[g]),
      .i_we    (w_bank_we),
      .i_be    (w_bank_be),
      .i_addr  (w_bank_addr),
      .i_wdata (w_bank_wdata),
      .o_rdata (w_bank_rdata[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Response stage 1. The source select (bypass or bank) only moves on a
  // read/bypass, and bank read registers only move on reads, so the muxed
  // data holds across writes. Reset selects the zeroed bypass register,
  // which gives rdata_o = 0 without resetting the macro outputs.
  // ---------------------------------------------------------------------------
  logic                  r_s1_valid;
  logic                  r_s1_bypass;
  logic [BANK_W-1:0]     r_s1_bank;
  logic [DATA_WIDTH-1:0] r_s1_wdata;
  logic [DATA_WIDTH-1:0] w_s1_rdata;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_bypass <= 1'b1;
      r_s1_bank   <= '0;
      r_s1_wdata  <= '0;
    end else begin
      r_s1_valid <= w_accept & (bypass_en_i | ~we_i);
      if (w_accept && bypass_en_i) begin
        r_s1_bypass <= 1'b1;
        r_s1_wdata  <= wdata_i;
      end else if (w_accept && !we_i) begin
        r_s1_bypass <= 1'b0;
        r_s1_bank   <= w_bank;
      end
    end
  end

  assign w_s1_rdata = r_s1_bypass ? r_s1_wdata : w_bank_rdata[r_s1_bank];

  // ---------------------------------------------------------------------------
  // Optional output register (read latency 2).
  // ---------------------------------------------------------------------------
  if (RDATA_REG != 0) begin : g_out_reg
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_rdata;

    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
        r_s2_valid <= 1'b0;
        r_s2_rdata <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_rdata <= w_s1_rdata;
        end
      end
    end

    assign rvalid_o = r_s2_valid;
    assign rdata_o  = r_s2_rdata;
  end else begin : g_out_comb
    assign rvalid_o = r_s1_valid;
    assign rdata_o  = w_s1_rdata;
  end

endmodule
